// File: rtl/digit_serial_adder_pkg.sv
// ============================================================================
// adder_pkg : shared FSM encoding and sizing helper for digit_serial_adder
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width for NDIG digits; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_serial_adder_if.sv
// ============================================================================
// digit_serial_adder_if : start/done handshake and operand/result bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output ready, busy, done, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/digit_serial_adder_ripple_digit.sv
// ============================================================================
// ripple_digit : DIGIT-bit combinational full-adder chain
// Rev 1.0
// ============================================================================
`default_nettype none

module ripple_digit #(
  parameter int DIGIT = 4
) (
  input  wire logic [DIGIT-1:0] a,
  input  wire logic [DIGIT-1:0] b,
  input  wire logic             ci,
  output logic      [DIGIT-1:0] s,
  output logic                  co,
  output logic                  c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co    = w_c[DIGIT];
  // Carry into the top bit; XOR with co gives signed overflow on the last digit.
  assign c_msb = w_c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/digit_serial_adder.sv
// ============================================================================
// digit_serial_adder : multi-cycle add/sub, DIGIT bits per clock, LSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  digit_serial_adder_if.slave bus
);

  localparam int            NDIG   = WIDTH / DIGIT;
  localparam int            CW     = clog2(NDIG);
  localparam logic [CW-1:0] K_LAST = CW'(NDIG - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    k_q;

  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;

  ripple_digit #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  // New digit enters at the top so the LSB digit ends up at bit 0 after NDIG shifts.
  if (DIGIT == WIDTH) begin : g_acc_full
    assign acc_d = w_s;
  end else begin : g_acc_shift
    assign acc_d = {w_s, acc_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.cin;
            k_q     <= '0;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_d;
          carry_q <= w_co;
          k_q     <= k_q + CW'(1);
          if (k_q == K_LAST) begin
            sum_q   <= acc_d;
            cout_q  <= w_co;
            ovf_q   <= w_co ^ w_cmsb;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

`default_nettype wire

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor. It accepts two WIDTH-bit operands on a start handshake and processes them DIGIT bits per clock, LSB digit first. A registered carry links the digits, and each digit is added by a small combinational ripple-carry slice. It is the area-optimised successor to the fixed 4-bit combinational ripple adder. It adds width/digit generalisation, a subtract mode, signed-overflow detection and a start/done handshake for sequential datapaths.

## Interface
- WIDTH, 16, operand and result width in bits. Must be ≥ 2.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.

Clocking: one clock; reset is synchronous and active-low.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only while ready=1.
- sub  in  1  0: a+b+cin; 1: a−b (a + ~b + 1, cin ignored). Sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in for add mode, sampled with start.
- ready  out  1  high in IDLE and DONE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse, high in DONE.
- sum  out  WIDTH  registered result.
- cout  out  1  final carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
State machine has three states: IDLE, RUN, DONE.

- **IDLE → RUN:** on start=1.
  - Latch a into the A shift register.
  - Latch b (or ~b when sub=1) into the B shift register.
  - Load the carry register with cin (or 1 when sub=1).
  - Clear the digit counter k.
- **RUN, each edge:** process digit k.
  - The slice adds the low DIGIT bits of the A and B shift registers plus the carry register.
  - The slice result is shifted into the top of the accumulator; A and B shift right by DIGIT.
  - The carry register takes the slice carry-out.
  - k increments.
  - On the last digit (k = NDIG−1), the carry into the slice's top bit is captured for ovf, and the state goes to DONE.
- **DONE, entry edge:** sum, cout and ovf are loaded from the accumulator and carry register in the same edge as the transition to DONE.
- **DONE → RUN or IDLE:** in DONE, start=1 is accepted exactly as in IDLE (back-to-back operation, → RUN). Otherwise → IDLE.
- **start in RUN:** ignored. There is no queuing and no abort.
- **Held results:** sum, cout and ovf hold their value until the next DONE entry or reset. They do not change during RUN.
- **Operand isolation:** changes on a, b, sub or cin after acceptance have no effect on the operation in flight.
- **Width rule:** sum is the result modulo 2^WIDTH. cout and ovf carry the extra information.
- **DIGIT=WIDTH:** a single RUN cycle; the design remains legal.

## Timing
- **Reset values:** state=IDLE, sum=0, cout=0, ovf=0, done=0, busy=0, ready=1. Internal registers and k are cleared.
- **Reset has priority over start.** rst_n=0 at any edge, including mid-RUN, aborts the operation. No done pulse is issued for the aborted operation.
- **Latency:** start is accepted at edge E0. done is high in the cycle following edge E_NDIG, i.e. NDIG clocks after acceptance.
- **Output timing:** sum, cout and ovf are valid from the same cycle that done is high.
- **Throughput:** one operation per NDIG+1 cycles with start held high.
- ready, busy and done are decoded from the state register only (Moore). There are no combinational paths from inputs to outputs.

## Structure
- **Package adder_pkg:**
  - state enum: IDLE, RUN, DONE.
  - function clog2 for sizing the digit counter (width clog2(NDIG), minimum 1).
- **Sub-module ripple_digit** (parameter DIGIT): combinational DIGIT-bit chain of full adders.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb (carry into the top bit, needed for ovf).
  - One instance.
- **Top level:** the FSM, shift registers, accumulator, carry and counter registers, and the output registers.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless stated.

1. a=0x1234, b=0x4321, cin=0, sub=0 → sum=0x5555, cout=0, ovf=0. done high exactly 4 clocks after the start edge, for one cycle only.
2. a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0 (carry crosses all digit boundaries). a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
3. Subtract mode:
   - sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0.
   - sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
   - sub=1 with cin=1 gives the same results as with cin=0.
4. Handshake:
   - Pulse start again and change a/b during RUN: the result is unaffected and ready stays low.
   - Hold start high: operations complete every 5 cycles.
5. Drive rst_n=0 for one edge after 2 RUN cycles (with prior sum=0x5555) → sum=0, ready=1, busy=0, no done pulse. A following start completes normally.
6. WIDTH=4, DIGIT=1 and WIDTH=8, DIGIT=8: run all operand/cin/sub combinations exhaustively against a golden model. Check latency is NDIG.
